// File: rtl/vsa_multicycle_if.sv
// vsa_multicycle_if
//   Bundles the instruction-fetch and data-memory handshakes of the
//   multicycle core.
//   master : the core (drives ifetch_req, PC, ALUOutput, dataout, mem_req,
//            wr, halted; receives instruction, ifetch_ack, datain, mem_ack)
//   slave  : the memory side (the mirror image)
interface vsa_multicycle_if #(
    parameter int DW  = 5,
    parameter int PCW = 5,
    parameter int RAW = 2
) ();
    localparam int IW = 3*RAW + 6;

    logic [IW-1:0]  instruction;
    logic           ifetch_req;
    logic           ifetch_ack;
    logic [PCW-1:0] PC;
    logic [DW-1:0]  ALUOutput;
    logic [DW-1:0]  datain;
    logic [DW-1:0]  dataout;
    logic           mem_req;
    logic           wr;
    logic           mem_ack;
    logic           halted;

    modport master (
        input  instruction, ifetch_ack, datain, mem_ack,
        output ifetch_req, PC, ALUOutput, dataout, mem_req, wr, halted
    );

    modport slave (
        output instruction, ifetch_ack, datain, mem_ack,
        input  ifetch_req, PC, ALUOutput, dataout, mem_req, wr, halted
    );
endinterface

// File: rtl/vsa_multicycle.sv
// vsa_multicycle
//   Non-pipelined multicycle processor: IF -> ID -> EX -> MEM -> WB, with
//   handshaked instruction fetch and data access, and a terminal HALT state.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (state IF, all registers zero)
//   bus   : vsa_multicycle_if.master (fetch, data bus, status)
module vsa_multicycle #(
    parameter int DW  = 5,
    parameter int PCW = 5,
    parameter int RAW = 2
) (
    input  logic             clock,
    input  logic             reset,
    vsa_multicycle_if.master bus
);
    localparam int NREG = 2**RAW;
    localparam int IW   = 3*RAW + 6;
    localparam int IMW  = RAW + 3;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    state_t                state, state_nxt;
    logic [PCW-1:0]        pc, npc, imm_pc, br_target;
    logic [IW-1:0]         ir;
    logic [DW-1:0]         a, b, alu_out, lmd, imm_dw;
    logic                  cond;
    logic [DW-1:0]         regs [NREG];
    logic [2:0]            opcode, funct;
    logic [RAW-1:0]        src1, src2, dst_r;
    logic signed [IMW-1:0] imm_s;
    logic                  is_mem, mem_exit, ifetch_req_c, mem_req_c;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] x,
                                             input logic [DW-1:0] y,
                                             input logic [2:0]    f);
        logic signed [DW-1:0] xs;
        xs = x;
        case (f)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return ~x;
            3'd6:    return x >> 1;
            default: return xs >>> 1;
        endcase
    endfunction

    // Field decode; for I-format the second register field is the I-dst,
    // which is also the store-data source for SW.
    assign opcode = ir[IW-1 -: 3];
    assign src1   = ir[IW-4 -: RAW];
    assign src2   = ir[IW-4-RAW -: RAW];
    assign dst_r  = ir[IW-4-2*RAW -: RAW];
    assign funct  = ir[2:0];
    assign imm_s  = ir[IMW-1:0];

    // Signed size casts sign-extend or truncate the immediate as needed.
    assign imm_dw    = DW'(imm_s);
    assign imm_pc    = PCW'(imm_s);
    assign br_target = npc + (imm_pc << 1);

    assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    assign mem_exit = (state == S_MEM) && (!is_mem || bus.mem_ack);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IF;
        else       state <= state_nxt;
    end

    // Next state and handshake requests
    always_comb begin
        state_nxt    = state;
        ifetch_req_c = 1'b0;
        mem_req_c    = 1'b0;
        case (state)
            S_IF: begin
                ifetch_req_c = 1'b1;
                if (bus.ifetch_ack) state_nxt = S_ID;
            end
            S_ID:  state_nxt = (opcode == OP_HALT) ? S_HALT : S_EX;
            S_EX:  state_nxt = S_MEM;
            S_MEM: begin
                mem_req_c = is_mem;
                if (mem_exit) state_nxt = S_WB;
            end
            S_WB:    state_nxt = S_IF;
            default: state_nxt = S_HALT;
        endcase
        // State is already IF during reset, but no fetch may be requested.
        if (reset) begin
            ifetch_req_c = 1'b0;
            mem_req_c    = 1'b0;
        end
    end

    // Datapath: each register is written only in its own state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            npc     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            cond    <= 1'b0;
            lmd     <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IF: begin
                    if (bus.ifetch_ack) begin
                        ir  <= bus.instruction;
                        npc <= pc + PCW'(2);
                    end
                end
                S_ID: begin
                    a <= (src1 == '0) ? '0 : regs[src1];
                    b <= (src2 == '0) ? '0 : regs[src2];
                end
                S_EX: begin
                    case (opcode)
                        OP_LW, OP_SW: alu_out <= a + imm_dw;
                        OP_ALU:       alu_out <= alu_fn(a, b, funct);
                        OP_ADDI:      alu_out <= a + imm_dw;
                        OP_SUBI:      alu_out <= a - imm_dw;
                        OP_BEQZ: begin
                            alu_out <= DW'(br_target);
                            cond    <= (a == '0);
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (is_mem && bus.mem_ack && (opcode == OP_LW)) lmd <= bus.datain;
                    if (mem_exit)
                        pc <= ((opcode == OP_BEQZ) && cond) ? PCW'(alu_out) : npc;
                end
                S_WB: begin
                    case (opcode)
                        OP_ALU:           if (dst_r != '0) regs[dst_r] <= alu_out;
                        OP_ADDI, OP_SUBI: if (src2 != '0) regs[src2] <= alu_out;
                        OP_LW:            if (src2 != '0) regs[src2] <= lmd;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.ifetch_req = ifetch_req_c;
    assign bus.mem_req    = mem_req_c;
    assign bus.wr         = mem_req_c && (opcode == OP_SW);
    assign bus.PC         = pc;
    assign bus.ALUOutput  = alu_out;
    assign bus.dataout    = b;
    assign bus.halted     = (state == S_HALT);
endmodule

// File: tb/tb_vsa_multicycle.sv
// tb_vsa_multicycle
//   Bench for vsa_multicycle: instruction ROM and data memory responders with
//   programmable ack latency, a store scoreboard, a table of ALU vectors and
//   hand-written sequences for stalls, branches, HALT and reset aborts.
module tb_vsa_multicycle;
    localparam int DW = 5, PCW = 5, RAW = 2, IW = 12;
    localparam logic [IW-1:0] HALT_I = {3'd6, 9'd0};
    localparam logic [IW-1:0] NOP_I  = {3'd7, 9'd0};

    logic clock = 1'b0;
    logic reset = 1'b1;

    vsa_multicycle_if #(.DW(DW), .PCW(PCW), .RAW(RAW)) bus ();
    vsa_multicycle #(.DW(DW), .PCW(PCW), .RAW(RAW)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct { logic [4:0] addr; logic [4:0] data; } st_t;
    typedef struct { int a; int b; logic [2:0] f; logic [4:0] exp; } vec_t;

    st_t           sb_q[$];
    int            fetch_log[$];
    logic [IW-1:0] imem [16];
    logic [DW-1:0] dmem [32];
    int            if_delay = 0, mem_delay = 0;
    bit            late_ack = 1'b0;
    int            n_vec = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc_i(input logic [2:0] op, input logic [1:0] s1,
                                            input logic [1:0] d, input logic [4:0] imm);
        return {op, s1, d, imm};
    endfunction

    function automatic logic [IW-1:0] enc_r(input logic [1:0] s1, input logic [1:0] s2,
                                            input logic [1:0] d, input logic [2:0] f);
        return {3'd3, s1, s2, d, f};
    endfunction

    // Memory responders act 1 time unit after the falling edge so that a
    // reset change made exactly at the falling edge is already visible.
    initial begin
        int  if_cnt;
        int  mem_cnt;
        st_t e;
        if_cnt = 0;
        mem_cnt = 0;
        bus.ifetch_ack  = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.instruction = '0;
        bus.datain      = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                bus.ifetch_ack = 1'b0;
                bus.mem_ack    = 1'b0;
                if_cnt  = 0;
                mem_cnt = 0;
            end else begin
                if (bus.ifetch_req && if_cnt >= if_delay) begin
                    bus.ifetch_ack  = 1'b1;
                    bus.instruction = imem[bus.PC[4:1]];
                    fetch_log.push_back(int'(bus.PC));
                    if_cnt = 0;
                end else begin
                    bus.ifetch_ack = late_ack;
                    if_cnt = bus.ifetch_req ? if_cnt + 1 : 0;
                end
                bus.datain = 5'($urandom);
                if (bus.mem_req && mem_cnt >= mem_delay) begin
                    bus.mem_ack = 1'b1;
                    mem_cnt = 0;
                    if (bus.wr) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_store", int'(bus.ALUOutput), -1);
                        end else begin
                            e = sb_q.pop_front();
                            check("store_addr", int'(bus.ALUOutput), int'(e.addr));
                            check("store_data", int'(bus.dataout), int'(e.data));
                        end
                    end else begin
                        bus.datain = dmem[bus.ALUOutput];
                    end
                end else begin
                    bus.mem_ack = late_ack;
                    mem_cnt = bus.mem_req ? mem_cnt + 1 : 0;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int k = 0; k < 16; k++) imem[k] = HALT_I;
        for (int k = 0; k < 32; k++) dmem[k] = '0;
    endtask

    // Returns on the falling edge where reset is released (core in IF).
    task automatic apply_reset(input bit chk);
        @(negedge clock);
        reset = 1'b1;
        #1;
        if (chk) begin
            check("rst_ifetch_req", int'(bus.ifetch_req), 0);
            check("rst_mem_req",    int'(bus.mem_req), 0);
            check("rst_wr",         int'(bus.wr), 0);
            check("rst_halted",     int'(bus.halted), 0);
            check("rst_pc",         int'(bus.PC), 0);
            check("rst_aluout",     int'(bus.ALUOutput), 0);
            check("rst_dataout",    int'(bus.dataout), 0);
        end
        @(negedge clock);
        @(negedge clock);
        fetch_log.delete();
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int cyc = 0;
        while (!bus.halted && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        check({name, "_halted"}, int'(bus.halted), 1);
        repeat (2) @(negedge clock);
        check({name, "_sb_left"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic check_fetch(input string name, input int ef[8], input int n);
        check({name, "_nfetch"}, fetch_log.size(), n);
        for (int k = 0; k < n && k < fetch_log.size(); k++)
            check($sformatf("%s_fetch%0d", name, k), fetch_log[k], ef[k]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        int   ef[8];
        int   cyc, mr, wrs, bad;

        vt[0]  = '{1,   2, 3'd1, 5'd31};
        vt[1]  = '{7,   5, 3'd0, 5'd12};
        vt[2]  = '{15, 15, 3'd0, 5'd30};
        vt[3]  = '{-16, -16, 3'd0, 5'd0};
        vt[4]  = '{12, 10, 3'd2, 5'd8};
        vt[5]  = '{12, 10, 3'd3, 5'd14};
        vt[6]  = '{12, 10, 3'd4, 5'd6};
        vt[7]  = '{12,  0, 3'd5, 5'd19};
        vt[8]  = '{-1,  0, 3'd6, 5'd15};
        vt[9]  = '{-1,  0, 3'd7, 5'd31};
        vt[10] = '{-16, 0, 3'd7, 5'd24};
        vt[11] = '{-16, 0, 3'd6, 5'd8};
        vt[12] = '{-16, 1, 3'd1, 5'd15};

        // ALU table: R1=a, R2=b, R3=R1 op R2, store R3 to address i.
        for (int i = 0; i < 13; i++) begin
            late_ack  = (i % 4 == 3);
            if_delay  = late_ack ? 0 : i % 3;
            mem_delay = late_ack ? 0 : (i + 1) % 3;
            clear_mem();
            imem[0] = enc_i(3'd4, 2'd0, 2'd1, 5'(vt[i].a));
            imem[1] = enc_i(3'd4, 2'd0, 2'd2, 5'(vt[i].b));
            imem[2] = enc_r(2'd1, 2'd2, 2'd3, vt[i].f);
            imem[3] = enc_i(3'd1, 2'd0, 2'd3, 5'(i));
            sb_q.push_back('{addr: 5'(i), data: vt[i].exp});
            apply_reset(i < 2);
            run_to_halt($sformatf("vec%0d", i), 400);
            check($sformatf("vec%0d_halt_pc", i), int'(bus.PC), 8);
        end
        late_ack = 1'b0;
        if_delay = 0;
        mem_delay = 0;

        // ADDI R1,R0,5 with immediate fetch: back in IF at PC=2 after 5 cycles.
        clear_mem();
        imem[0] = 12'h825;
        imem[1] = enc_i(3'd1, 2'd0, 2'd1, 5'd0);
        sb_q.push_back('{addr: 5'd0, data: 5'd5});
        apply_reset(1'b0);
        mr = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.mem_req) mr++;
            @(negedge clock);
        end
        check("addi_pc_after5", int'(bus.PC), 2);
        check("addi_ifetch_after5", int'(bus.ifetch_req), 1);
        check("addi_mem_req_cycles", mr, 0);
        run_to_halt("addi", 100);

        // LW R2,0(R0) with ack after 3 wait cycles, datain=9.
        clear_mem();
        dmem[0] = 5'd9;
        imem[0] = enc_i(3'd0, 2'd0, 2'd2, 5'd0);
        imem[1] = enc_i(3'd1, 2'd0, 2'd2, 5'd1);
        sb_q.push_back('{addr: 5'd1, data: 5'd9});
        mem_delay = 3;
        apply_reset(1'b0);
        cyc = 0; mr = 0; wrs = 0;
        while (!(bus.ifetch_req && bus.PC == 5'd2) && cyc < 50) begin
            if (bus.mem_req) mr++;
            if (bus.wr) wrs++;
            @(negedge clock);
            cyc++;
        end
        check("lw_cycles", cyc, 8);
        check("lw_mem_req_cycles", mr, 4);
        check("lw_wr_cycles", wrs, 0);
        run_to_halt("lw", 100);
        mem_delay = 0;

        // BEQZ taken at PC=4 (R0) to 12, then not taken at PC=12 (R1=5).
        clear_mem();
        imem[0] = enc_i(3'd4, 2'd0, 2'd1, 5'd5);
        imem[1] = NOP_I;
        imem[2] = enc_i(3'd2, 2'd0, 2'd0, 5'd3);
        imem[6] = enc_i(3'd2, 2'd1, 2'd0, 5'd3);
        imem[7] = enc_i(3'd1, 2'd0, 2'd1, 5'd2);
        sb_q.push_back('{addr: 5'd2, data: 5'd5});
        apply_reset(1'b0);
        run_to_halt("beqz_t", 200);
        ef = '{0, 2, 4, 12, 14, 16, 0, 0};
        check_fetch("beqz_t", ef, 6);
        check("beqz_t_halt_pc", int'(bus.PC), 16);

        // BEQZ on R1=5 at PC=4 falls through to 6.
        clear_mem();
        imem[0] = enc_i(3'd4, 2'd0, 2'd1, 5'd5);
        imem[1] = NOP_I;
        imem[2] = enc_i(3'd2, 2'd1, 2'd0, 5'd3);
        imem[3] = enc_i(3'd1, 2'd0, 2'd1, 5'd3);
        sb_q.push_back('{addr: 5'd3, data: 5'd5});
        apply_reset(1'b0);
        run_to_halt("beqz_nt", 200);
        ef = '{0, 2, 4, 6, 8, 0, 0, 0};
        check_fetch("beqz_nt", ef, 5);

        // R0 discards writes; SUBI with negative immediate; LW via base.
        clear_mem();
        dmem[11] = 5'd21;
        imem[0] = enc_i(3'd4, 2'd0, 2'd1, 5'd7);
        imem[1] = enc_r(2'd1, 2'd1, 2'd0, 3'd0);
        imem[2] = enc_i(3'd4, 2'd0, 2'd0, 5'd3);
        imem[3] = enc_i(3'd1, 2'd0, 2'd0, 5'd0);
        imem[4] = enc_i(3'd5, 2'd1, 2'd2, 5'(-9));
        imem[5] = enc_i(3'd1, 2'd1, 2'd2, 5'd4);
        imem[6] = enc_i(3'd0, 2'd2, 2'd3, 5'(-5));
        imem[7] = enc_i(3'd1, 2'd0, 2'd3, 5'd0);
        sb_q.push_back('{addr: 5'd0,  data: 5'd0});
        sb_q.push_back('{addr: 5'd11, data: 5'd16});
        sb_q.push_back('{addr: 5'd0,  data: 5'd21});
        apply_reset(1'b0);
        run_to_halt("r0", 300);

        // HALT: halted from the cycle after ID, PC frozen, acks ignored.
        clear_mem();
        imem[0] = NOP_I;
        apply_reset(1'b0);
        cyc = 0;
        while (!bus.halted && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check("halt_latency", cyc, 7);
        check("halt_pc", int'(bus.PC), 2);
        late_ack = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.ifetch_req || bus.mem_req || !bus.halted || bus.PC != 5'd2) bad++;
        end
        check("halt_stuck_violations", bad, 0);
        check("halt_nfetch", fetch_log.size(), 2);
        late_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("halt_rst_halted", int'(bus.halted), 0);
        check("halt_rst_pc", int'(bus.PC), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("halt_rel_ifetch_req", int'(bus.ifetch_req), 1);
        check("halt_rel_pc", int'(bus.PC), 0);

        // Reset during a LW stall aborts the load.
        clear_mem();
        dmem[0] = 5'd9;
        imem[0] = enc_i(3'd4, 2'd0, 2'd2, 5'd3);
        imem[1] = enc_i(3'd0, 2'd0, 2'd2, 5'd0);
        mem_delay = 1000;
        apply_reset(1'b0);
        cyc = 0;
        while (!bus.mem_req && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("stall_mem_req_seen", int'(bus.mem_req), 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("stall_rst_mem_req", int'(bus.mem_req), 0);
        check("stall_rst_ifetch_req", int'(bus.ifetch_req), 0);
        clear_mem();
        imem[0] = enc_i(3'd1, 2'd0, 2'd2, 5'd0);
        mem_delay = 0;
        sb_q.push_back('{addr: 5'd0, data: 5'd0});
        @(negedge clock);
        @(negedge clock);
        fetch_log.delete();
        reset = 1'b0;
        run_to_halt("stall", 100);
        if (fetch_log.size() > 0) check("stall_first_fetch_pc", fetch_log[0], 0);
        else                      check("stall_nfetch", fetch_log.size(), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vsa_multicycle.md
VSA_MULTICYCLE -- requirements
Module: vsa_multicycle

Interface
REQ-001 Parameter DW, default 5: data/register width in bits.
REQ-002 Parameter PCW, default 5: program counter width in bits.
REQ-003 Parameter RAW, default 2: register address width; register count NREG = 2**RAW; instruction width IW = 3*RAW+6; immediate width IMW = RAW+3.
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-005 clock  in  1  master clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 instruction  in  IW  instruction fetch data.
REQ-008 ifetch_req  out  1  fetch request; PC is valid while high.
REQ-009 ifetch_ack  in  1  fetch acknowledge; instruction is valid in the same cycle.
REQ-010 PC  out  PCW  instruction address.
REQ-011 ALUOutput  out  DW  data address / ALU result register.
REQ-012 datain  in  DW  load data bus.
REQ-013 dataout  out  DW  store data bus; always equals B.
REQ-014 mem_req  out  1  data access request in MEM for LW/SW.
REQ-015 wr  out  1  mem_req high and opcode SW.
REQ-016 mem_ack  in  1  data access complete; datain is valid in the same cycle.
REQ-017 halted  out  1  high in state HALT.

Function
REQ-018 Instruction formats: R = opcode[3] src1[RAW] src2[RAW] dst[RAW] funct[3]; I = opcode[3] src1[RAW] dst[RAW] imm[IMW].
REQ-019 Opcodes: 0 LW, 1 SW, 2 BEQZ, 3 ALU, 4 ADDI, 5 SUBI, 6 HALT, 7 NOP.
REQ-020 Funct codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A), 6 SRL by 1, 7 SRA by 1.
REQ-021 Imm SHALL be imm sign-extended (or truncated) to DW; all arithmetic SHALL be modulo 2**DW, with PC arithmetic modulo 2**PCW.
REQ-022 Register 0 SHALL always read zero, and writes to it SHALL be discarded.
REQ-023 States: IF, ID, EX, MEM, WB, HALT.
REQ-024 IF: ifetch_req=1; stay in IF until ifetch_ack; on ack, IR<=instruction, NPC<=PC+2, go to ID.
REQ-025 ID: A<=R[src1], B<=R[src2]; HALT opcode goes to HALT; all other opcodes go to EX.
REQ-026 EX: LW/SW ALUOutput<=A+Imm; ALU per funct; ADDI A+Imm; SUBI A-Imm; BEQZ ALUOutput<=NPC+(Imm<<1), Cond<=(A==0); NOP no change; go to MEM.
REQ-027 MEM for LW/SW: mem_req=1 until mem_ack; stay in MEM while ack is low; on ack, LW loads LMD<=datain; then exit.
REQ-028 MEM for other opcodes: exit after one cycle with mem_req=0.
REQ-029 On MEM exit: PC<=ALUOutput if BEQZ and Cond, else PC<=NPC; go to WB.
REQ-030 WB: ALU writes R[dst]; ADDI/SUBI write R[I-dst]; LW writes R[I-dst]<=LMD; all other opcodes write nothing; go to IF.
REQ-031 A and B SHALL change only in ID, and the register file SHALL change only in WB.
REQ-032 HALT: terminal state; ifetch_req=0, mem_req=0, PC frozen; left only by reset.
REQ-033 A late ack SHALL be ignored: ifetch_ack outside IF and mem_ack outside a LW/SW MEM cycle have no effect.
REQ-034 Minimum latency SHALL be 5 cycles per instruction, plus one cycle for each fetch or memory wait cycle.

Reset
REQ-035 While reset is high, state=IF and PC, NPC, IR, A, B, ALUOutput, Cond, LMD and all registers SHALL be 0.
REQ-036 While reset is high, ifetch_req=0, mem_req=0, wr=0 and halted=0.
REQ-037 Reset asserted in any state, including a MEM stall or HALT, SHALL abort the instruction with no register write; after release, fetch restarts at PC=0.

Verification (defaults DW=5, PCW=5, RAW=2, IW=12)
REQ-038 ADDI R1,R0,5 (0x825), ifetch_ack tied high -> R1=5 after 5 cycles, PC=2, mem_req never asserted.
REQ-039 LW R2,0(R0) with mem_ack delayed 3 cycles and datain=9 -> mem_req high 4 cycles, wr=0, R2=9, instruction takes 8 cycles.
REQ-040 R1=1, R2=2, SUB R3=R1-R2 -> R3=31; SRA on R3 -> 31; SRL on R3 -> 15.
REQ-041 BEQZ R0, imm=3 at PC=4 -> PC=12; the same instruction with src1=R1 (R1=5) -> PC=6.
REQ-042 HALT opcode -> halted=1 from the cycle after ID, PC unchanged, no further ifetch_req; reset -> PC=0, state IF.
REQ-043 Reset pulse during a LW MEM stall -> no register write, mem_req=0 immediately, first fetch after release at PC=0.
